// File: rtl/mem_stage_if.sv
// EX->MEM request and MEM->WB result bundle for mem_stage_param.
// The master drives the EX-side request fields; the slave (MEM stage) drives stall and results.
interface mem_stage_if #(
  parameter int WB_W = 2,
  parameter int RA_W = 5
);
  logic            valid_i;
  logic            flush_i;
  logic [WB_W-1:0] wb_i;
  logic [1:0]      m_i;
  logic [1:0]      size_i;
  logic            unsigned_i;
  logic [31:0]     addr_i;
  logic [31:0]     wdata_i;
  logic [RA_W-1:0] rd_i;
  logic            stall_o;
  logic            valid_o;
  logic [WB_W-1:0] wb_o;
  logic [31:0]     read_data_o;
  logic [31:0]     addr_o;
  logic [RA_W-1:0] rd_o;
  logic            misalign_o;

  modport master (
    output valid_i, flush_i, wb_i, m_i, size_i, unsigned_i, addr_i, wdata_i, rd_i,
    input  stall_o, valid_o, wb_o, read_data_o, addr_o, rd_o, misalign_o
  );

  modport slave (
    input  valid_i, flush_i, wb_i, m_i, size_i, unsigned_i, addr_i, wdata_i, rd_i,
    output stall_o, valid_o, wb_o, read_data_o, addr_o, rd_o, misalign_o
  );
endinterface

// File: rtl/mem_stage_param.sv
// MEM pipeline stage: data RAM with byte/half/word access, optional wait states, MEM/WB register.
// Optional feature macro: MEM_ALIGN_CHECK_EN (flag and suppress misaligned half/word accesses).
module mem_stage_param #(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 0,
  parameter int WB_W        = 2,
  parameter int RA_W        = 5
) (
  input logic         clk,
  input logic         rst_n,
  mem_stage_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00: r[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (lane[1]) r[31:16] = wd[15:0];
        else         r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      default: return |lane;
    endcase
  endfunction
`endif

  logic [31:0]     r_mem [DEPTH];
  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic            w_stall, w_complete, w_memop, w_mis, w_we;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_word, w_rdata;
  logic            r_valid;
  logic [WB_W-1:0] r_wb;
  logic [31:0]     r_rdata, r_addr;
  logic [RA_W-1:0] r_rd;

  assign w_memop = bus.valid_i & (|bus.m_i) & ~bus.flush_i;
  assign w_idx   = bus.addr_i[AW+1:2];
  assign w_word  = r_mem[w_idx];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_mis = (|bus.m_i) & is_misaligned(bus.size_i, bus.addr_i[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  // Read-before-write: load data always comes from the pre-store RAM word.
  assign w_rdata = (bus.m_i[1] & ~w_mis)
                 ? load_extend(w_word, bus.size_i, bus.addr_i[1:0], bus.unsigned_i)
                 : 32'd0;
  assign w_we    = rst_n & w_complete & bus.m_i[0] & ~w_mis;

  // Stage boundary: FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_memop && (WAIT_CYCLES > 0)) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = WAIT_LOAD;
          w_stall     = 1'b1;
        end else begin
          w_complete  = bus.valid_i & ~bus.flush_i;
        end
      end
      S_WAIT: begin
        if (bus.flush_i) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nxt   = r_cnt - 4'd1;
          w_stall     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_complete  = bus.valid_i;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign bus.stall_o = w_stall & rst_n;

  // Stage boundary: MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_wb    <= '0;
      r_rdata <= 32'd0;
      r_addr  <= 32'd0;
      r_rd    <= '0;
    end else if (w_complete) begin
      r_valid <= 1'b1;
      r_wb    <= bus.wb_i;
      r_rdata <= w_rdata;
      r_addr  <= bus.addr_i;
      r_rd    <= bus.rd_i;
    end else begin
      r_valid <= 1'b0;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic r_misalign;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_misalign <= 1'b0;
    else if (w_complete) r_misalign <= w_mis;
  end
  assign bus.misalign_o = r_misalign;
`else
  assign bus.misalign_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_idx] <= store_merge(w_word, bus.wdata_i, bus.size_i, bus.addr_i[1:0]);
  end

  assign bus.valid_o     = r_valid;
  assign bus.wb_o        = r_wb;
  assign bus.read_data_o = r_rdata;
  assign bus.addr_o      = r_addr;
  assign bus.rd_o        = r_rd;
endmodule

// File: tb/tb_mem_stage_param.sv
// Directed bench for mem_stage_param: three instances with 0, 2 and 3 wait states share one stimulus set.
module tb_mem_stage_param;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v2, v3, fl, uns;
  logic [1:0]  wb, m, sz;
  logic [31:0] addr, wdata;
  logic [4:0]  rd;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  mem_stage_if #(.WB_W(2), .RA_W(5)) if0 ();
  mem_stage_if #(.WB_W(2), .RA_W(5)) if2 ();
  mem_stage_if #(.WB_W(2), .RA_W(5)) if3 ();

  always_comb begin
    if0.valid_i = v0; if0.flush_i = fl; if0.wb_i = wb; if0.m_i = m; if0.size_i = sz;
    if0.unsigned_i = uns; if0.addr_i = addr; if0.wdata_i = wdata; if0.rd_i = rd;
  end
  always_comb begin
    if2.valid_i = v2; if2.flush_i = fl; if2.wb_i = wb; if2.m_i = m; if2.size_i = sz;
    if2.unsigned_i = uns; if2.addr_i = addr; if2.wdata_i = wdata; if2.rd_i = rd;
  end
  always_comb begin
    if3.valid_i = v3; if3.flush_i = fl; if3.wb_i = wb; if3.m_i = m; if3.size_i = sz;
    if3.unsigned_i = uns; if3.addr_i = addr; if3.wdata_i = wdata; if3.rd_i = rd;
  end

  mem_stage_param #(.DEPTH(32), .WAIT_CYCLES(0), .WB_W(2), .RA_W(5)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  mem_stage_param #(.DEPTH(32), .WAIT_CYCLES(2), .WB_W(2), .RA_W(5)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  mem_stage_param #(.DEPTH(32), .WAIT_CYCLES(3), .WB_W(2), .RA_W(5)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] mm, input logic [1:0] s, input logic u,
                    input logic [31:0] a, input logic [31:0] d);
    m = mm; sz = s; uns = u; addr = a; wdata = d; rd = a[6:2]; wb = s;
  endtask

  // Hold the current op on dut2 (is3=0) or dut3 (is3=1) through its stall window.
  task automatic run_waited(input string tag, input bit is3, input int waits);
    for (int k = 0; k < waits; k++) begin
      #1;
      check({tag, " stall"}, 32'(is3 ? if3.stall_o : if2.stall_o), 32'd1);
      tick();
      check({tag, " bubble"}, 32'(is3 ? if3.valid_o : if2.valid_o), 32'd0);
    end
    #1;
    check({tag, " stall end"}, 32'(is3 ? if3.stall_o : if2.stall_o), 32'd0);
    tick();
    check({tag, " valid"}, 32'(is3 ? if3.valid_o : if2.valid_o), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; v0 = 0; v2 = 0; v3 = 0; fl = 0;
    op(2'b00, 2'b00, 1'b0, 32'd0, 32'd0);
    tick(); tick();
    check("rst valid0", 32'(if0.valid_o), 32'd0);
    check("rst rdata0", if0.read_data_o, 32'd0);
    check("rst addr3", if3.addr_o, 32'd0);
    check("rst stall2", 32'(if2.stall_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // zero-wait word store/load
    v0 = 1;
    op(2'b01, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
    #1 check("sw stall", 32'(if0.stall_o), 32'd0);
    tick();
    check("sw valid", 32'(if0.valid_o), 32'd1);
    check("sw addr", if0.addr_o, 32'h8);
    check("sw rd", 32'(if0.rd_o), 32'd2);
    check("sw rdata", if0.read_data_o, 32'd0);
    op(2'b10, 2'b10, 1'b0, 32'h8, 32'h0);
    #1 check("lw stall", 32'(if0.stall_o), 32'd0);
    tick();
    check("lw data", if0.read_data_o, 32'hDEADBEEF);
    check("lw valid", 32'(if0.valid_o), 32'd1);

    // sub-word store and extension
    op(2'b01, 2'b00, 1'b0, 32'h9, 32'h12345680); tick();
    op(2'b10, 2'b00, 1'b0, 32'h9, 32'h0); tick();
    check("lb", if0.read_data_o, 32'hFFFFFF80);
    op(2'b10, 2'b00, 1'b1, 32'h9, 32'h0); tick();
    check("lbu", if0.read_data_o, 32'h00000080);
    op(2'b10, 2'b10, 1'b0, 32'h8, 32'h0); tick();
    check("lw merged", if0.read_data_o, 32'hDEAD80EF);
    op(2'b10, 2'b01, 1'b0, 32'hA, 32'h0); tick();
    check("lh hi", if0.read_data_o, 32'hFFFFDEAD);
    check("lh wb", 32'(if0.wb_o), 32'd1);
    op(2'b10, 2'b01, 1'b1, 32'h8, 32'h0); tick();
    check("lhu lo", if0.read_data_o, 32'h000080EF);

    // bubble, then read-before-write
    v0 = 0; tick();
    check("bubble valid", 32'(if0.valid_o), 32'd0);
    check("bubble hold", if0.read_data_o, 32'h000080EF);
    v0 = 1;
    op(2'b11, 2'b10, 1'b0, 32'h8, 32'h11223344); tick();
    check("rbw old", if0.read_data_o, 32'hDEAD80EF);
    op(2'b10, 2'b10, 1'b0, 32'h8, 32'h0); tick();
    check("rbw new", if0.read_data_o, 32'h11223344);

    // misaligned half store and word load
    op(2'b01, 2'b10, 1'b0, 32'h0, 32'hAABBCCDD); tick();
    op(2'b01, 2'b01, 1'b0, 32'h3, 32'h00005566); tick();
    op(2'b10, 2'b10, 1'b0, 32'h0, 32'h0); tick();
`ifdef MEM_ALIGN_CHECK_EN
    check("sh misaligned", if0.read_data_o, 32'hAABBCCDD);
    op(2'b10, 2'b10, 1'b0, 32'hB, 32'h0); tick();
    check("lw mis data", if0.read_data_o, 32'd0);
    check("lw mis flag", 32'(if0.misalign_o), 32'd1);
`else
    check("sh forced", if0.read_data_o, 32'h5566CCDD);
    op(2'b10, 2'b10, 1'b0, 32'hB, 32'h0); tick();
    check("lw forced", if0.read_data_o, 32'h11223344);
    check("misalign tied", 32'(if0.misalign_o), 32'd0);
`endif

    // address wrap
    op(2'b01, 2'b10, 1'b0, 32'h80, 32'hCAFEF00D); tick();
    op(2'b10, 2'b10, 1'b0, 32'h0, 32'h0); tick();
    check("wrap", if0.read_data_o, 32'hCAFEF00D);
    v0 = 0;

    // three wait states
    v3 = 1;
    op(2'b01, 2'b10, 1'b0, 32'h10, 32'h0BADF00D);
    run_waited("w3 sw", 1'b1, 3);
    op(2'b10, 2'b10, 1'b0, 32'h10, 32'h0);
    run_waited("w3 lw", 1'b1, 3);
    check("w3 lw data", if3.read_data_o, 32'h0BADF00D);
    v3 = 0;

    // two wait states, store flushed in second stall cycle
    v2 = 1;
    op(2'b01, 2'b10, 1'b0, 32'h20, 32'h11111111);
    run_waited("w2 sw", 1'b0, 2);
    op(2'b01, 2'b10, 1'b0, 32'h20, 32'h22222222);
    #1 check("flush stall0", 32'(if2.stall_o), 32'd1);
    tick();
    fl = 1;
    #1 check("flush stall1", 32'(if2.stall_o), 32'd0);
    tick();
    check("flush valid", 32'(if2.valid_o), 32'd0);
    fl = 0; v2 = 0; tick();
    v2 = 1;
    op(2'b10, 2'b10, 1'b0, 32'h20, 32'h0);
    run_waited("w2 lw", 1'b0, 2);
    check("flush old data", if2.read_data_o, 32'h11111111);
    v2 = 0;

    // async reset in the middle of a waited store
    v3 = 1;
    op(2'b01, 2'b10, 1'b0, 32'h10, 32'hFFFFFFFF);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst valid", 32'(if3.valid_o), 32'd0);
    check("arst addr", if3.addr_o, 32'd0);
    check("arst rdata", if3.read_data_o, 32'd0);
    check("arst rd", 32'(if3.rd_o), 32'd0);
    check("arst stall", 32'(if3.stall_o), 32'd0);
    v3 = 0;
    tick();
    rst_n = 1'b1;
    tick();
    v3 = 1;
    op(2'b10, 2'b10, 1'b0, 32'h10, 32'h0);
    run_waited("post rst lw", 1'b1, 3);
    check("abandoned store", if3.read_data_o, 32'h0BADF00D);
    v3 = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
